// File: rtl/mmult_pkg.sv
// rtl/mmult_pkg.sv - shared widths and state encoding for the matrix-multiply host loader
package mmult_pkg;

  localparam int ELEM_W        = 16;
  localparam int N_ELEM        = 16;
  localparam int WORD_W        = 128;
  localparam int RES_W         = 32;
  localparam int ELEM_PER_WORD = WORD_W / ELEM_W;
  localparam int CNT_W         = 5;
  localparam int IDX_W         = 4;
  localparam int MULT_W        = N_ELEM * RES_W;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/mmult_result_ser.sv
// rtl/mmult_result_ser.sv - captures the 512-bit product and serializes it as 32-bit valid/ready beats
module mmult_result_ser
  import mmult_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic              capture,
  input  logic [MULT_W-1:0] mult_out,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_data,
  output logic              out_valid,
  output logic              last_xfer
);

  logic [N_ELEM-1:0][RES_W-1:0] result_q, result_d;
  logic [IDX_W-1:0]             out_idx_q, out_idx_d;
  logic                         valid_q, valid_d;
  logic                         xfer;

  assign xfer      = valid_q && out_ready;
  assign last_xfer = xfer && (out_idx_q == IDX_W'(N_ELEM - 1));
  assign out_valid = valid_q;
  assign out_data  = valid_q ? result_q[out_idx_q] : '0;

  // Capture loads the whole product and restarts at element 0; each handshake steps one element.
  always_comb begin
    result_d  = result_q;
    out_idx_d = out_idx_q;
    valid_d   = valid_q;
    if (capture) begin
      result_d  = mult_out;
      out_idx_d = '0;
      valid_d   = 1'b1;
    end else if (xfer) begin
      out_idx_d = out_idx_q + 1'b1;
      if (last_xfer) begin
        valid_d = 1'b0;
      end
    end
  end

  // Clear wins over capture so a reset mid-drain always leaves the serializer idle.
  always_ff @(posedge clk) begin
    if (clear) begin
      result_q  <= '0;
      out_idx_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      result_q  <= result_d;
      out_idx_q <= out_idx_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: rtl/mmult_host_loader.sv
// rtl/mmult_host_loader.sv - packs operand elements into SRAM words, runs the core, streams the product
module mmult_host_loader #(
  parameter int ELEM_W = mmult_pkg::ELEM_W,
  parameter int N_ELEM = mmult_pkg::N_ELEM,
  parameter int WORD_W = mmult_pkg::WORD_W,
  parameter int RES_W  = mmult_pkg::RES_W
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [ELEM_W-1:0]       In_Data,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  output logic [WORD_W-1:0]       MA_dib,
  output logic [WORD_W-1:0]       MB_dib,
  output logic                    MA_Addrb,
  output logic                    MB_Addrb,
  output logic                    MA_enb,
  output logic                    MB_enb,
  output logic                    MA_web,
  output logic                    MB_web,
  output logic                    Go_t,
  input  logic                    Done_t,
  input  logic [N_ELEM*RES_W-1:0] MULT_OUT_t,
  output logic [RES_W-1:0]        Out_Data,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic                    Busy
);

  import mmult_pkg::*;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         elem_cnt_q, elem_cnt_d;
  // Only the seven most recent elements need holding; the eighth arrives on In_Data.
  logic [WORD_W-ELEM_W-1:0] pack_q, pack_d;
  logic [WORD_W-1:0]        word_full;
  logic                     wr_a_q, wr_a_d;
  logic                     wr_b_q, wr_b_d;
  logic                     wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]        wr_data_q, wr_data_d;
  logic                     go_q, go_d;
  logic                     accept;
  logic                     capture;
  logic                     last_xfer;

  assign In_Ready  = (state_q == LOAD) && !Rst;
  assign accept    = In_Valid && In_Ready;
  assign word_full = {In_Data, pack_q};
  assign capture   = (state_q == RUN) && Done_t;

  assign MA_enb   = wr_a_q;
  assign MA_web   = wr_a_q;
  assign MA_Addrb = wr_a_q & wr_addr_q;
  assign MA_dib   = wr_a_q ? wr_data_q : '0;
  assign MB_enb   = wr_b_q;
  assign MB_web   = wr_b_q;
  assign MB_Addrb = wr_b_q & wr_addr_q;
  assign MB_dib   = wr_b_q ? wr_data_q : '0;

  assign Go_t = go_q;
  assign Busy = (state_q != LOAD) || (elem_cnt_q != '0);

  // Next-state, packing and write-pulse decode; the write pulse defaults low every cycle.
  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    pack_d     = pack_q;
    go_d       = go_q;
    wr_a_d     = 1'b0;
    wr_b_d     = 1'b0;
    wr_addr_d  = 1'b0;
    wr_data_d  = '0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          pack_d     = word_full[WORD_W-1:ELEM_W];
          elem_cnt_d = elem_cnt_q + 1'b1;
          if (elem_cnt_q[2:0] == 3'd7) begin
            wr_a_d    = !elem_cnt_q[4];
            wr_b_d    = elem_cnt_q[4];
            wr_addr_d = elem_cnt_q[3];
            wr_data_d = word_full;
          end
          if (elem_cnt_q == CNT_W'(2 * N_ELEM - 1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      RUN: begin
        if (Done_t) begin
          go_d    = 1'b0;
          state_d = DRAIN;
        end else begin
          go_d = 1'b1;
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Reset aborts any transaction, including a write pulse that would otherwise fire next cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= LOAD;
      elem_cnt_q <= '0;
      pack_q     <= '0;
      go_q       <= 1'b0;
      wr_a_q     <= 1'b0;
      wr_b_q     <= 1'b0;
      wr_addr_q  <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      pack_q     <= pack_d;
      go_q       <= go_d;
      wr_a_q     <= wr_a_d;
      wr_b_q     <= wr_b_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  mmult_result_ser u_result_ser (
    .clk       (Clk),
    .clear     (Rst),
    .capture   (capture),
    .mult_out  (MULT_OUT_t),
    .out_ready (Out_Ready),
    .out_data  (Out_Data),
    .out_valid (Out_Valid),
    .last_xfer (last_xfer)
  );

endmodule

// File: tb/tb_mmult_host_loader.sv
// tb/tb_mmult_host_loader.sv - self-checking bench for mmult_host_loader
module tb_mmult_host_loader;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [15:0]  In_Data;
  logic         In_Valid;
  logic         In_Ready;
  logic [127:0] MA_dib, MB_dib;
  logic         MA_Addrb, MB_Addrb, MA_enb, MB_enb, MA_web, MB_web;
  logic         Go_t;
  logic         Done_t;
  logic [511:0] MULT_OUT_t;
  logic [31:0]  Out_Data;
  logic         Out_Valid;
  logic         Out_Ready;
  logic         Busy;

  mmult_host_loader dut (
    .Clk(Clk), .Rst(Rst), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .MA_dib(MA_dib), .MB_dib(MB_dib), .MA_Addrb(MA_Addrb), .MB_Addrb(MB_Addrb),
    .MA_enb(MA_enb), .MB_enb(MB_enb), .MA_web(MA_web), .MB_web(MB_web),
    .Go_t(Go_t), .Done_t(Done_t), .MULT_OUT_t(MULT_OUT_t),
    .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Operand SRAM port-B model.
  logic [127:0] mem_a [2];
  logic [127:0] mem_b [2];
  always @(negedge Clk) begin
    if (MA_enb && MA_web) mem_a[MA_Addrb] = MA_dib;
    if (MB_enb && MB_web) mem_b[MB_Addrb] = MB_dib;
  end

  // Multiply core model: reads the operands back from the SRAM model.
  function automatic logic [511:0] core_product();
    logic [15:0]  a [16];
    logic [15:0]  b [16];
    logic [511:0] r;
    logic [31:0]  s;
    for (int e = 0; e < 16; e++) begin
      a[e] = mem_a[e / 8][16 * (e % 8) +: 16];
      b[e] = mem_b[e / 8][16 * (e % 8) +: 16];
    end
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += 32'(a[i * 4 + k]) * 32'(b[k * 4 + j]);
        r[32 * (i * 4 + j) +: 32] = s;
      end
    return r;
  endfunction

  function automatic logic [511:0] junk512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32 * i +: 32] = $urandom;
    return r;
  endfunction

  typedef struct {
    int mode;        // 0 identity x 1..16, 1 random, 2 all ones
    int done_dly;    // cycles Go_t is held before Done_t
    int gap_pct;     // chance of an In_Valid bubble
    int rdy_mode;    // 0 always ready, 1 pattern 1,0,0,1, 2 random
    int spur_done;   // pulse Done_t during LOAD
    int exp_writes;
    int exp_go_lat;  // edges from last accept to Go_t rise, -1 if Go_t never rises
  } vec_t;

  vec_t vecs [6];

  task automatic run_txn(input vec_t v, input string tag);
    logic [15:0]  el [32];
    logic [31:0]  exp_out [16];
    logic [31:0]  s;
    logic [127:0] ma0, ma1;
    int acc [32];
    int n_in = 0, n_out = 0, e_last = -1, n_wr = 0, go_rise = -1, start, rp = 0, w;
    int bad_wr = 0, bad_go = 0, bad_ov = 0, bad_od = 0, bad_rdy = 0;
    logic go_prev = 1'b0, exp_go, exp_ov, exp_a, exp_b, exp_ad;
    ma0 = '0;
    ma1 = '0;
    for (int i = 0; i < 32; i++) begin
      acc[i] = -1;
      case (v.mode)
        0:       el[i] = (i < 16) ? ((i % 5 == 0) ? 16'd1 : 16'd0) : 16'(i - 15);
        1:       el[i] = 16'($urandom_range(0, 65535));
        default: el[i] = 16'hFFFF;
      endcase
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += 32'(el[r * 4 + k]) * 32'(el[16 + k * 4 + c]);
        exp_out[r * 4 + c] = s;
      end
    start = cyc;
    while (n_out < 16 && cyc - start < 800) begin
      @(negedge Clk);
      // write pulse expected in the cycle after the accept of a word's 8th element
      w = -1;
      for (int i = 7; i < 32; i += 8) if (acc[i] == cyc) w = i;
      exp_a  = (w >= 0) && (w < 16);
      exp_b  = (w >= 16);
      exp_ad = (w >= 0) && ((w % 16) >= 8);
      n_wr += int'(MA_enb) + int'(MB_enb);
      if ({MA_enb, MA_web, MB_enb, MB_web, MA_Addrb, MB_Addrb} !==
          {exp_a, exp_a, exp_b, exp_b, exp_a & exp_ad, exp_b & exp_ad}) bad_wr++;
      if (!MA_enb && MA_dib !== '0) bad_wr++;
      if (!MB_enb && MB_dib !== '0) bad_wr++;
      if (MA_enb && !MA_Addrb) ma0 = MA_dib;
      if (MA_enb && MA_Addrb) ma1 = MA_dib;
      exp_go = (e_last >= 0) && (cyc >= e_last + 2) && (cyc < e_last + 2 + v.done_dly);
      if (Go_t !== exp_go) bad_go++;
      if (Go_t && !go_prev && go_rise < 0) go_rise = cyc;
      go_prev = Go_t;
      exp_ov = (e_last >= 0) && (cyc >= e_last + 2 + v.done_dly);
      if (Out_Valid !== exp_ov) bad_ov++;
      if (Out_Valid && Out_Data !== exp_out[n_out]) bad_od++;
      if (In_Ready !== (e_last < 0)) bad_rdy++;
      // drive inputs for the next edge
      if (n_in < 32) begin
        In_Valid = ($urandom_range(0, 99) >= v.gap_pct);
        In_Data  = In_Valid ? el[n_in] : 16'($urandom);
        if (In_Valid && In_Ready) begin
          acc[n_in] = cyc + 1;
          if (n_in == 31) e_last = cyc + 1;
          n_in++;
        end
      end else begin
        In_Valid = 1'($urandom);
        In_Data  = 16'($urandom);
      end
      if (e_last >= 0 && cyc + 1 == e_last + 2 + v.done_dly) begin
        Done_t     = 1'b1;
        MULT_OUT_t = core_product();
      end else begin
        Done_t     = (e_last >= 0 && cyc + 1 > e_last + 2 + v.done_dly) ? 1'($urandom) :
                     (v.spur_done != 0 && n_in == 5);
        MULT_OUT_t = junk512();
      end
      case (v.rdy_mode)
        0:       Out_Ready = 1'b1;
        1:       Out_Ready = (rp % 4 == 0) || (rp % 4 == 3);
        default: Out_Ready = 1'($urandom);
      endcase
      rp++;
      if (Out_Valid && Out_Ready) n_out++;
    end
    @(negedge Clk);
    In_Valid  = 1'b0;
    Done_t    = 1'b0;
    Out_Ready = 1'b0;
    chk({tag, " completed"}, n_out, 16);
    chk({tag, " write_count"}, n_wr, v.exp_writes);
    chk({tag, " write_timing"}, bad_wr, 0);
    chk({tag, " go_latency"}, (go_rise < 0) ? -1 : go_rise - e_last, v.exp_go_lat);
    chk({tag, " go_window"}, bad_go, 0);
    chk({tag, " out_valid"}, bad_ov, 0);
    chk({tag, " out_data"}, bad_od, 0);
    chk({tag, " in_ready"}, bad_rdy, 0);
    chk({tag, " busy_end"}, Busy, 1'b0);
    chk({tag, " in_ready_end"}, In_Ready, 1'b1);
    if (v.mode == 0) begin
      chk({tag, " ident_ma0"}, ma0, 128'h0000_0000_0001_0000_0000_0000_0000_0001);
      chk({tag, " ident_ma1"}, ma1, 128'h0001_0000_0000_0000_0000_0001_0000_0000);
    end
  endtask

  task automatic push(input int n);
    int k = 0, t = 0;
    In_Valid = 1'b1;
    while (k < n && t < 200) begin
      In_Data = 16'($urandom);
      if (In_Ready) k++;
      @(negedge Clk);
      t++;
    end
    In_Valid = 1'b0;
    chk("push_accepts", k, n);
  endtask

  initial begin
    int t;
    vecs[0] = '{0,  3,  0, 0, 0, 4,  2};
    vecs[1] = '{1,  0,  0, 0, 0, 4, -1};
    vecs[2] = '{1, 20, 30, 1, 0, 4,  2};
    vecs[3] = '{2,  5,  0, 2, 0, 4,  2};
    vecs[4] = '{1,  7, 50, 2, 1, 4,  2};
    vecs[5] = '{1,  1, 10, 1, 0, 4,  2};

    Rst = 1'b1; In_Valid = 1'b0; In_Data = '0; Done_t = 1'b0; MULT_OUT_t = '0; Out_Ready = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_in_ready", In_Ready, 1'b0);
    chk("rst_go", Go_t, 1'b0);
    chk("rst_out_valid", Out_Valid, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_wr_en", {MA_enb, MA_web, MB_enb, MB_web, MA_Addrb, MB_Addrb}, 6'b0);
    chk("rst_dib", {MA_dib, MB_dib}, '0);
    chk("rst_out_data", Out_Data, 32'd0);
    Rst = 1'b0;
    @(negedge Clk);
    chk("idle_in_ready", In_Ready, 1'b1);

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of LOAD after element 11.
    push(12);
    chk("midload_busy_before", Busy, 1'b1);
    Rst = 1'b1;
    @(negedge Clk);
    chk("midload_go", Go_t, 1'b0);
    chk("midload_no_write", {MA_enb, MB_enb}, 2'b00);
    chk("midload_cnt_clear", Busy, 1'b0);
    Rst = 1'b0;
    @(negedge Clk);
    run_txn(vecs[0], "after_midload");

    // Reset in the middle of RUN while Go_t is held.
    push(32);
    t = 0;
    while (!Go_t && t < 20) begin @(negedge Clk); t++; end
    chk("midrun_go_seen", Go_t, 1'b1);
    Rst = 1'b1;
    @(negedge Clk);
    chk("midrun_go", Go_t, 1'b0);
    chk("midrun_out_valid", Out_Valid, 1'b0);
    chk("midrun_cnt_clear", Busy, 1'b0);
    Rst = 1'b0;
    Done_t = 1'b1;
    @(negedge Clk);
    Done_t = 1'b0;
    chk("midrun_done_ignored", Out_Valid, 1'b0);
    run_txn(vecs[2], "after_midrun");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
